button_conditioner: RTL and testbench
=====================================

# button_conditioner

Input conditioning stage directly upstream of the password-lock FSM in `ChipInterface`. It takes the five raw push-button levels: `enter0`, `enter1`, `confirm`, `clear` and `algorithm_select_mode`. For each button it synchronizes the level, debounces it, and detects the press edge. The output is a single-cycle, one-event-at-a-time stream (`event_valid` + `event_code`) that the FSM consumes. Simultaneous and overlapping presses are arbitrated here, so the FSM never sees two button events in one cycle.

## Interface
- `SYNC_STAGES`, default 2: flip-flop depth of each input synchronizer (≥2).
- `DEBOUNCE_CYCLES`, default 2: consecutive identical synchronized samples required to change a debounced level (≥1).
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `enter0`  in  1  raw button level.
- `enter1`  in  1  raw button level.
- `confirm`  in  1  raw button level.
- `clear`  in  1  raw button level.
- `algorithm_select_mode`  in  1  raw button level.
- `event_valid`  out  1  registered; one-cycle pulse per accepted press.
- `event_code`  out  3  registered; 0=enter0, 1=enter1, 2=confirm, 3=clear, 4=select. Holds its last value when `event_valid`=0. Codes 5–7 are never produced.
- `conflict`  out  1  registered; one-cycle pulse when a press is rejected.
- `busy`  out  1  registered; 1 while the arbiter is in HELD.

## Operation
- Per button: a `SYNC_STAGES` flop chain produces `s`. A debouncer holds level `db` and counter `cnt`.
  - Each edge where `s != db`: `cnt` increments.
  - When `cnt == DEBOUNCE_CYCLES-1` and `s != db`: `db <= s` and `cnt <= 0`.
  - Each edge where `s == db`: `cnt <= 0`.
- Press: `db` rises 0→1. Release: `db` falls 1→0. Releases produce no event.
- Arbiter FSM, states IDLE and HELD.
  - IDLE, one or more presses in the same cycle: accept the highest priority, clear > confirm > select > enter1 > enter0. Emit its event and go to HELD, recording the accepted button. If more than one press occurred, also pulse `conflict`.
  - HELD, any new press of a different button: no event, pulse `conflict`.
  - HELD → IDLE when every `db` is 0. A button still held when the accepted one releases never produces an event; it must release and press again.
- At most one `event_valid` per press. Never two events in consecutive cycles.
- Reset (any time, including mid-debounce or in HELD):
  - Clears synchronizers, `db`, `cnt` and state to IDLE.
  - Clears `event_valid`, `conflict` and `busy` to 0, and `event_code` to 0.
  - A button held through reset deassertion is treated as a fresh press after the normal latency.

## Timing
- Raw level first sampled high at edge k:
  - `s` is high after edge k+`SYNC_STAGES`-1.
  - `db` rises at edge k+`SYNC_STAGES`+`DEBOUNCE_CYCLES`-1.
  - `event_valid`/`event_code` go high at edge k+`SYNC_STAGES`+`DEBOUNCE_CYCLES` for exactly one cycle. With defaults this is k+4.
- Minimum recognized press: `DEBOUNCE_CYCLES` consecutive high samples. With defaults, a 1-cycle glitch is rejected and the system's standard 3-cycle press is accepted.
- Release follows the same latency. `busy` falls one edge after the last `db` falls.
- A 3-cycle press followed by a 3-cycle gap yields one event per 6 cycles, with no loss.
- `conflict` is asserted in the same cycle as the event it accompanies, or alone when rejected in HELD.

## Test plan
- `enter1` high for 3 cycles starting at edge 10 → `event_valid`=1, `event_code`=1 in the cycle after edge 14 only; `busy` is 1 from edge 14 and falls after release is debounced.
- `confirm` high for 1 cycle → no `event_valid`, no `conflict`, `busy` stays 0.
- `confirm` and `enter0` rise in the same cycle, held 3 cycles → single event with code 2 and `conflict`=1 in the same cycle; no code-0 event afterwards.
- `enter1` held 8 cycles; `enter0` pressed 3 cycles starting 2 cycles after `enter1` → one code-1 event and one `conflict` pulse, no code-0 event. After both release, an `enter0` press → code-0 event.
- Drive the sequence 1,0,1,1,0,1,confirm using 3-on/3-off presses → seven events with codes 1,0,1,1,0,1,2 in order, spaced 6 cycles apart.
- `clear` raised, `reset` pulsed 2 cycles after the rise, `clear` dropped before debounce completes → no event. All outputs read 0 during and after reset.

Source files
------------

// File: rtl/button_conditioner.sv
// Five-button input conditioner: per-button synchronizer, debouncer and press
// detector, followed by a two-state arbiter that emits one event at a time.
module button_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enter0,
    input  logic       enter1,
    input  logic       confirm,
    input  logic       clear,
    input  logic       algorithm_select_mode,
    output logic       event_valid,
    output logic [2:0] event_code,
    output logic       conflict,
    output logic       busy
);

    // state | meaning
    // IDLE  | no button accepted; next press (highest priority) becomes an event
    // HELD  | a press was accepted; wait until every debounced level is low
    typedef enum logic {IDLE, HELD} state_t;

    localparam int N  = 5;
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [N-1:0]           raw;
    logic [SYNC_STAGES-1:0] sync_chain [N];
    logic [N-1:0]           s;
    logic [N-1:0]           db;
    logic [N-1:0]           db_prev;
    logic [CW-1:0]          cnt [N];
    logic [N-1:0]           press;
    logic [N-1:0]           held_mask;

    state_t     state, state_next;
    logic [2:0] held, held_next;
    logic [2:0] win_code;
    logic       multi;
    logic       event_valid_d;
    logic [2:0] event_code_d;
    logic       conflict_d;

    // Bit index equals the event code.
    assign raw = {algorithm_select_mode, clear, confirm, enter1, enter0};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                sync_chain[i] <= '0;
                cnt[i]        <= '0;
            end
            db      <= '0;
            db_prev <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                sync_chain[i] <= {sync_chain[i][SYNC_STAGES-2:0], raw[i]};
                if (s[i] != db[i]) begin
                    if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        db[i]  <= s[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
            db_prev <= db;
        end
    end

    always_comb begin
        s = '0;
        for (int i = 0; i < N; i++) s[i] = sync_chain[i][SYNC_STAGES-1];
    end

    assign press     = db & ~db_prev;
    assign multi     = (press & (press - N'(1))) != '0;
    assign held_mask = N'(1) << held;

    // Priority: clear > confirm > select > enter1 > enter0
    always_comb begin
        win_code = 3'd0;
        if (press[3])      win_code = 3'd3;
        else if (press[2]) win_code = 3'd2;
        else if (press[4]) win_code = 3'd4;
        else if (press[1]) win_code = 3'd1;
    end

    always_comb begin
        state_next    = state;
        held_next     = held;
        event_valid_d = 1'b0;
        event_code_d  = event_code;
        conflict_d    = 1'b0;
        case (state)
            IDLE: begin
                if (|press) begin
                    event_valid_d = 1'b1;
                    event_code_d  = win_code;
                    conflict_d    = multi;
                    held_next     = win_code;
                    state_next    = HELD;
                end
            end
            HELD: begin
                if (|(press & ~held_mask)) conflict_d = 1'b1;
                if (db == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            held        <= 3'd0;
            event_valid <= 1'b0;
            event_code  <= 3'd0;
            conflict    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            held        <= held_next;
            event_valid <= event_valid_d;
            event_code  <= event_code_d;
            conflict    <= conflict_d;
            busy        <= (state_next == HELD);
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: each task drives one scenario and
// checks logged events, conflicts and busy edges against hand-computed cycles.
module tb_button_conditioner;

    logic       clock;
    logic       reset;
    logic       enter0, enter1, confirm, clear, algorithm_select_mode;
    logic       event_valid;
    logic [2:0] event_code;
    logic       conflict;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int ev_code[$];
    int ev_cyc[$];
    int cf_cyc[$];
    int busy_rise[$];
    int busy_fall[$];
    logic busy_prev = 1'b0;

    button_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(2)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .enter0                (enter0),
        .enter1                (enter1),
        .confirm               (confirm),
        .clear                 (clear),
        .algorithm_select_mode (algorithm_select_mode),
        .event_valid           (event_valid),
        .event_code            (event_code),
        .conflict              (conflict),
        .busy                  (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Event log sampled mid-cycle; cyc equals the edge that produced the value.
    always @(negedge clock) begin
        if (!reset) begin
            if (event_valid) begin
                ev_code.push_back(int'(event_code));
                ev_cyc.push_back(cyc);
            end
            if (conflict) cf_cyc.push_back(cyc);
            if (busy && !busy_prev) busy_rise.push_back(cyc);
            if (!busy && busy_prev) busy_fall.push_back(cyc);
        end
        busy_prev = busy;
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        ev_code.delete();
        ev_cyc.delete();
        cf_cyc.delete();
        busy_rise.delete();
        busy_fall.delete();
    endtask

    task automatic set_btn(input int code, input logic v);
        case (code)
            0: enter0 = v;
            1: enter1 = v;
            2: confirm = v;
            3: clear = v;
            default: algorithm_select_mode = v;
        endcase
    endtask

    task automatic test_reset();
        checks++;
        if ({event_valid, event_code, conflict, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=000000", {event_valid, event_code, conflict, busy});
        end
        reset = 1'b0;
        wait_edges(8);
        checks++;
        if (ev_code.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset events=%0d busy=%b exp events=0 busy=0", ev_code.size(), busy);
        end
    endtask

    task automatic test_enter1();
        int k;
        clear_log();
        k = cyc + 1;
        enter1 = 1'b1;
        wait_edges(3);
        enter1 = 1'b0;
        wait_edges(12);
        checks++;
        if (ev_code.size() != 1) begin
            failures++;
            $display("FAIL enter1_count got=%0d exp=1", ev_code.size());
        end else begin
            checks++;
            if (ev_code[0] != 1 || ev_cyc[0] != k + 4) begin
                failures++;
                $display("FAIL enter1_event got code=%0d cyc=%0d exp code=1 cyc=%0d", ev_code[0], ev_cyc[0], k + 4);
            end
        end
        checks++;
        if (cf_cyc.size() != 0) begin
            failures++;
            $display("FAIL enter1_conflict got=%0d exp=0", cf_cyc.size());
        end
        checks++;
        if (busy_rise.size() != 1 || busy_fall.size() != 1) begin
            failures++;
            $display("FAIL enter1_busy_edges got rise=%0d fall=%0d exp 1 1", busy_rise.size(), busy_fall.size());
        end else begin
            checks++;
            if (busy_rise[0] != k + 4 || busy_fall[0] != k + 7) begin
                failures++;
                $display("FAIL enter1_busy_timing got rise=%0d fall=%0d exp rise=%0d fall=%0d",
                         busy_rise[0], busy_fall[0], k + 4, k + 7);
            end
        end
        checks++;
        if (event_code !== 3'd1 || event_valid !== 1'b0) begin
            failures++;
            $display("FAIL code_hold got code=%0d valid=%b exp code=1 valid=0", event_code, event_valid);
        end
    endtask

    task automatic test_glitch();
        clear_log();
        confirm = 1'b1;
        wait_edges(1);
        confirm = 1'b0;
        wait_edges(12);
        checks++;
        if (ev_code.size() != 0 || cf_cyc.size() != 0 || busy_rise.size() != 0) begin
            failures++;
            $display("FAIL glitch got events=%0d conflicts=%0d busy_rises=%0d exp 0 0 0",
                     ev_code.size(), cf_cyc.size(), busy_rise.size());
        end
    endtask

    task automatic test_simultaneous();
        int k;
        clear_log();
        k = cyc + 1;
        confirm = 1'b1;
        enter0  = 1'b1;
        wait_edges(3);
        confirm = 1'b0;
        enter0  = 1'b0;
        wait_edges(12);
        checks++;
        if (ev_code.size() != 1) begin
            failures++;
            $display("FAIL simul_count got=%0d exp=1", ev_code.size());
        end else begin
            checks++;
            if (ev_code[0] != 2 || ev_cyc[0] != k + 4) begin
                failures++;
                $display("FAIL simul_event got code=%0d cyc=%0d exp code=2 cyc=%0d", ev_code[0], ev_cyc[0], k + 4);
            end
        end
        checks++;
        if (cf_cyc.size() != 1) begin
            failures++;
            $display("FAIL simul_conflict_count got=%0d exp=1", cf_cyc.size());
        end else begin
            checks++;
            if (cf_cyc[0] != k + 4) begin
                failures++;
                $display("FAIL simul_conflict_cyc got=%0d exp=%0d", cf_cyc[0], k + 4);
            end
        end
    endtask

    task automatic test_overlap();
        int k, k2;
        clear_log();
        k = cyc + 1;
        enter1 = 1'b1;
        wait_edges(2);
        enter0 = 1'b1;
        wait_edges(3);
        enter0 = 1'b0;
        wait_edges(3);
        enter1 = 1'b0;
        wait_edges(10);
        k2 = cyc + 1;
        enter0 = 1'b1;
        wait_edges(3);
        enter0 = 1'b0;
        wait_edges(12);
        checks++;
        if (ev_code.size() != 2) begin
            failures++;
            $display("FAIL overlap_count got=%0d exp=2", ev_code.size());
        end else begin
            checks++;
            if (ev_code[0] != 1 || ev_cyc[0] != k + 4 || ev_code[1] != 0 || ev_cyc[1] != k2 + 4) begin
                failures++;
                $display("FAIL overlap_events got %0d@%0d %0d@%0d exp 1@%0d 0@%0d",
                         ev_code[0], ev_cyc[0], ev_code[1], ev_cyc[1], k + 4, k2 + 4);
            end
        end
        checks++;
        if (cf_cyc.size() != 1) begin
            failures++;
            $display("FAIL overlap_conflict_count got=%0d exp=1", cf_cyc.size());
        end else begin
            checks++;
            if (cf_cyc[0] != k + 6) begin
                failures++;
                $display("FAIL overlap_conflict_cyc got=%0d exp=%0d", cf_cyc[0], k + 6);
            end
        end
    endtask

    task automatic test_back_to_back();
        int seq[7] = '{1, 0, 1, 1, 0, 1, 2};
        int k;
        clear_log();
        k = cyc + 1;
        for (int i = 0; i < 7; i++) begin
            set_btn(seq[i], 1'b1);
            wait_edges(3);
            set_btn(seq[i], 1'b0);
            wait_edges(3);
        end
        wait_edges(10);
        checks++;
        if (ev_code.size() != 7) begin
            failures++;
            $display("FAIL seq_count got=%0d exp=7", ev_code.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (ev_code[i] != seq[i] || ev_cyc[i] != k + 4 + 6 * i) begin
                    failures++;
                    $display("FAIL seq_event%0d got code=%0d cyc=%0d exp code=%0d cyc=%0d",
                             i, ev_code[i], ev_cyc[i], seq[i], k + 4 + 6 * i);
                end
            end
        end
        checks++;
        if (cf_cyc.size() != 0) begin
            failures++;
            $display("FAIL seq_conflict got=%0d exp=0", cf_cyc.size());
        end
    endtask

    task automatic test_reset_mid_debounce();
        clear_log();
        clear = 1'b1;
        wait_edges(2);
        reset = 1'b1;
        #1;
        checks++;
        if ({event_valid, event_code, conflict, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_async got=%b exp=000000", {event_valid, event_code, conflict, busy});
        end
        wait_edges(1);
        clear = 1'b0;
        wait_edges(1);
        checks++;
        if ({event_valid, event_code, conflict, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_during got=%b exp=000000", {event_valid, event_code, conflict, busy});
        end
        reset = 1'b0;
        wait_edges(12);
        checks++;
        if (ev_code.size() != 0 || cf_cyc.size() != 0 || busy_rise.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_events got events=%0d conflicts=%0d busy_rises=%0d exp 0 0 0",
                     ev_code.size(), cf_cyc.size(), busy_rise.size());
        end
        checks++;
        if ({event_valid, event_code, conflict, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_after got=%b exp=000000", {event_valid, event_code, conflict, busy});
        end
    endtask

    task automatic test_hold_through_reset();
        int k;
        enter0 = 1'b1;
        wait_edges(6);
        reset = 1'b1;
        wait_edges(2);
        clear_log();
        reset = 1'b0;
        k = cyc + 1;
        wait_edges(8);
        enter0 = 1'b0;
        wait_edges(10);
        checks++;
        if (ev_code.size() != 1) begin
            failures++;
            $display("FAIL hold_reset_count got=%0d exp=1", ev_code.size());
        end else begin
            checks++;
            if (ev_code[0] != 0 || ev_cyc[0] != k + 4) begin
                failures++;
                $display("FAIL hold_reset_event got code=%0d cyc=%0d exp code=0 cyc=%0d", ev_code[0], ev_cyc[0], k + 4);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        enter0 = 1'b0;
        enter1 = 1'b0;
        confirm = 1'b0;
        clear  = 1'b0;
        algorithm_select_mode = 1'b0;
        wait_edges(3);
        test_reset();
        test_enter1();
        test_glitch();
        test_simultaneous();
        test_overlap();
        test_back_to_back();
        test_reset_mid_debounce();
        test_hold_through_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
